kms_event_decoder: RTL

//  Consumes the toggle-level keyboard/mouse event stream from the HPS I/O block
//  (level, type, data) and turns it into Amiga-side state.
//  - Mouse: 8-bit wrapping X/Y position counters and a button register.
//  - Keyboard: keycodes queued in a small FIFO for the CIA keyboard serializer.
//  - OSD: keycodes emitted as one-cycle strobes.
//  - Reset request: Ctrl+LAmiga+RAmiga chord detection.

---
 rtl/kms_pkg.sv | 13 +
 rtl/kms_event_decoder_if.sv | 21 ++
 rtl/kms_fifo.sv | 59 +++++
 rtl/kms_event_decoder.sv | 97 +++++++++
 4 files changed

// File: rtl/kms_pkg.sv
// Shared constants for the keyboard/mouse event decoder: event types and chord keycodes.
package kms_pkg;

  localparam logic [1:0] KMS_MOUSE_X = 2'd0;
  localparam logic [1:0] KMS_MOUSE_Y = 2'd1;
  localparam logic [1:0] KMS_KEY     = 2'd2;
  localparam logic [1:0] KMS_OSD     = 2'd3;

  localparam logic [6:0] KEY_CTRL    = 7'h63;
  localparam logic [6:0] KEY_LAMIGA  = 7'h66;
  localparam logic [6:0] KEY_RAMIGA  = 7'h67;

endpackage

// File: rtl/kms_event_decoder_if.sv
// Event stream from the HPS I/O block plus the keycode stream to the CIA keyboard serializer.
interface kms_event_decoder_if;

    logic       kms_level;
    logic [1:0] kms_type;
    logic [7:0] kms_data;
    logic [7:0] kbd_code;
    logic       kbd_valid;
    logic       kbd_ready;

    modport master (
        output kms_level, kms_type, kms_data, kbd_ready,
        input  kbd_code, kbd_valid
    );

    modport slave (
        input  kms_level, kms_type, kms_data, kbd_ready,
        output kbd_code, kbd_valid
    );

endinterface

// File: rtl/kms_fifo.sv
// Show-ahead FIFO with a sticky overflow flag; a full FIFO still accepts a push when it pops.
module kms_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overflow
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             wr;

    assign full     = count[AW];
    assign valid    = (count != '0);
    assign pop      = valid & ready;
    assign wr       = push & (~full | pop);
    // Head is masked while empty so discarded contents never show after reset.
    assign data_out = valid ? mem[rptr] : '0;

    // NOTE: storage has no reset; only pointers and count need a known state.
    always_ff @(posedge clk_sys) begin
        if (wr) mem[wptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/kms_event_decoder.sv
// Decodes toggle-level HPS keyboard/mouse events into mouse counters, a keycode FIFO,
// OSD strobes and the Ctrl+LAmiga+RAmiga reset chord.
module kms_event_decoder
    import kms_pkg::*;
#(
    parameter int KBD_FIFO_AW = 3
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    kms_event_decoder_if.slave        bus,
    input  logic [2:0]                mouse_btn_in,
    output logic [7:0]                mouse_x,
    output logic [7:0]                mouse_y,
    output logic [2:0]                mouse_btn,
    output logic [7:0]                osd_code,
    output logic                      osd_strobe,
    output logic                      kbd_reset,
    output logic                      kbd_overflow,
    input  logic                      ovf_clr
);

    logic level_q;
    logic armed;
    logic event_valid;
    logic key_event;
    logic ctrl_held, lamiga_held, ramiga_held;
    logic ctrl_next, lamiga_next, ramiga_next;

    // The first post-reset cycle only arms, so a level left high across reset is not an event.
    assign event_valid = armed & (bus.kms_level ^ level_q);
    assign key_event   = event_valid & (bus.kms_type == KMS_KEY);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ctrl_next   = ctrl_held;
        lamiga_next = lamiga_held;
        ramiga_next = ramiga_held;
        if (key_event) begin
            case (bus.kms_data[6:0])
                KEY_CTRL:   ctrl_next   = ~bus.kms_data[7];
                KEY_LAMIGA: lamiga_next = ~bus.kms_data[7];
                KEY_RAMIGA: ramiga_next = ~bus.kms_data[7];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= 1'b0;
            armed       <= 1'b0;
            mouse_x     <= '0;
            mouse_y     <= '0;
            mouse_btn   <= '0;
            osd_code    <= '0;
            osd_strobe  <= 1'b0;
            ctrl_held   <= 1'b0;
            lamiga_held <= 1'b0;
            ramiga_held <= 1'b0;
            kbd_reset   <= 1'b0;
        end else begin
            level_q     <= bus.kms_level;
            armed       <= 1'b1;
            mouse_btn   <= mouse_btn_in;
            osd_strobe  <= event_valid & (bus.kms_type == KMS_OSD);
            ctrl_held   <= ctrl_next;
            lamiga_held <= lamiga_next;
            ramiga_held <= ramiga_next;
            // Registered from the next-state flags so the chord shows one cycle after its last key.
            kbd_reset   <= ctrl_next & lamiga_next & ramiga_next;
            if (event_valid) begin
                case (bus.kms_type)
                    KMS_MOUSE_X: mouse_x  <= mouse_x + bus.kms_data;
                    KMS_MOUSE_Y: mouse_y  <= mouse_y + bus.kms_data;
                    KMS_OSD:     osd_code <= bus.kms_data;
                    default:     ;
                endcase
            end
        end
    end

    kms_fifo #(
        .WIDTH (8),
        .AW    (KBD_FIFO_AW)
    ) u_kbd_fifo (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .push      (key_event),
        .push_data (bus.kms_data),
        .ready     (bus.kbd_ready),
        .ovf_clr   (ovf_clr),
        .data_out  (bus.kbd_code),
        .valid     (bus.kbd_valid),
        .overflow  (kbd_overflow)
    );

endmodule
